// File: rtl/any1_pkg.sv
// Shared types and helpers for the ANY-1 load/store path: access size codes,
// func-code to size mapping, sequencer state encoding and max legal size per bus width.
package any1_pkg;

  typedef enum logic [2:0] {
    SZ_BYTE  = 3'd0,
    SZ_WYDE  = 3'd1,
    SZ_TETRA = 3'd2,
    SZ_OCTA  = 3'd3,
    SZ_HEXI  = 3'd4,
    SZ_DHEXI = 3'd5,
    SZ_QHEXI = 3'd6,
    SZ_RSVD  = 3'd7
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } sel_state_e;

  localparam logic [3:0] FN_LDB = 4'h0;
  localparam logic [3:0] FN_LDW = 4'h1;
  localparam logic [3:0] FN_LDT = 4'h2;
  localparam logic [3:0] FN_LDO = 4'h3;
  localparam logic [3:0] FN_LDH = 4'h4;
  localparam logic [3:0] FN_STB = 4'h8;
  localparam logic [3:0] FN_STW = 4'h9;
  localparam logic [3:0] FN_STT = 4'hA;
  localparam logic [3:0] FN_STO = 4'hB;
  localparam logic [3:0] FN_STH = 4'hC;

  // Unknown func codes map to SZ_RSVD so the sequencer flags them as illegal.
  function automatic size_e func_to_size(input logic [3:0] fn);
    case (fn)
      FN_LDB, FN_STB: return SZ_BYTE;
      FN_LDW, FN_STW: return SZ_WYDE;
      FN_LDT, FN_STT: return SZ_TETRA;
      FN_LDO, FN_STO: return SZ_OCTA;
      FN_LDH, FN_STH: return SZ_HEXI;
      default:        return SZ_RSVD;
    endcase
  endfunction

  function automatic logic [2:0] max_size(input int dbw);
    return 3'($clog2(dbw / 8));
  endfunction

endpackage

// File: rtl/any1_sel_mask.sv
// Combinational byte-lane mask: (2^(2^size) - 1) << off, 2*NB bits wide, so the
// upper half holds the lanes that spill into the next bus word.
module any1_sel_mask
  import any1_pkg::*;
#(
  parameter int NB  = 16,
  parameter int LNB = $clog2(NB)
) (
  input  logic [LNB-1:0]  off_i,
  input  size_e           size_i,
  output logic [2*NB-1:0] mask_o
);

  logic [2*NB-1:0] base;

  always_comb begin
    base = '0;
    for (int i = 0; i < NB; i++) begin
      base[i] = (i < (1 << size_i));
    end
    mask_o = base << off_i;
  end

endmodule

// File: rtl/any1_sel_seq.sv
// Byte-lane select sequencer: one request in, one or two registered bus beats out.
// Define ANY1_SEL_SPLIT_EN to split word-crossing accesses; otherwise they fault.
//
// state    | meaning
// ST_IDLE  | ready for a request
// ST_BEAT0 | first (or only) beat presented
// ST_BEAT1 | spill-over beat into the next bus word (split build only)
module any1_sel_seq
  import any1_pkg::*;
#(
  parameter int DBW = 128,
  parameter int ABW = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [ABW-1:0]             req_adr_i,
  input  logic [2:0]                 req_size_i,
  input  logic                       req_we_i,
  output logic                       beat_valid_o,
  input  logic                       beat_ready_i,
  output logic [ABW-1:0]             beat_adr_o,
  output logic [DBW/8-1:0]           beat_sel_o,
  output logic [$clog2(DBW/8)-1:0]   beat_ofs_o,
  output logic                       beat_we_o,
  output logic                       beat_first_o,
  output logic                       beat_last_o,
  output logic                       err_o
);

  localparam int          NB     = DBW / 8;
  localparam int          LNB    = $clog2(NB);
  localparam logic [2:0]  MAX_SZ = max_size(DBW);

  sel_state_e     state_q, state_d;
  logic           ready_q, ready_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic           we_q, we_d;
  logic           first_q, first_d;
  logic           last_q, last_d;
  logic [ABW-1:0] adr_q, adr_d;
  logic [NB-1:0]  sel_q, sel_d;
  logic [LNB-1:0] ofs_q, ofs_d;
`ifdef ANY1_SEL_SPLIT_EN
  logic [NB-1:0]  hi_q, hi_d;
`endif

  logic [LNB-1:0]  req_off;
  logic [ABW-1:0]  req_aln;
  logic [2*NB-1:0] mask;
  logic [NB-1:0]   lo, hi;
  logic            size_ok;

  assign req_off = req_adr_i[LNB-1:0];
  assign req_aln = {req_adr_i[ABW-1:LNB], {LNB{1'b0}}};
  assign size_ok = (req_size_i <= MAX_SZ);
  assign lo      = mask[NB-1:0];
  assign hi      = mask[2*NB-1:NB];

  any1_sel_mask #(
    .NB  (NB),
    .LNB (LNB)
  ) u_mask (
    .off_i  (req_off),
    .size_i (size_e'(req_size_i)),
    .mask_o (mask)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    we_d    = we_q;
    first_d = first_q;
    last_d  = last_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    ofs_d   = ofs_q;
`ifdef ANY1_SEL_SPLIT_EN
    hi_d    = hi_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (!size_ok) begin
            err_d = 1'b1;
          end
`ifndef ANY1_SEL_SPLIT_EN
          else if (hi != '0) begin
            err_d = 1'b1;
          end
`endif
          else begin
            state_d = ST_BEAT0;
            valid_d = 1'b1;
            adr_d   = req_aln;
            sel_d   = lo;
            ofs_d   = req_off;
            we_d    = req_we_i;
            first_d = 1'b1;
            last_d  = (hi == '0);
`ifdef ANY1_SEL_SPLIT_EN
            hi_d    = hi;
`endif
          end
        end
      end
      ST_BEAT0: begin
        if (beat_ready_i) begin
`ifdef ANY1_SEL_SPLIT_EN
          if (last_q) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end else begin
            // ofs_q still holds the request offset; beat 1 resumes after NB-off bytes
            state_d = ST_BEAT1;
            adr_d   = adr_q + ABW'(NB);
            sel_d   = hi_q;
            ofs_d   = LNB'(NB - int'(ofs_q));
            first_d = 1'b0;
            last_d  = 1'b1;
          end
`else
          state_d = ST_IDLE;
          valid_d = 1'b0;
`endif
        end
      end
`ifdef ANY1_SEL_SPLIT_EN
      ST_BEAT1: begin
        if (beat_ready_i) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      ofs_q   <= '0;
`ifdef ANY1_SEL_SPLIT_EN
      hi_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      we_q    <= we_d;
      first_q <= first_d;
      last_q  <= last_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      ofs_q   <= ofs_d;
`ifdef ANY1_SEL_SPLIT_EN
      hi_q    <= hi_d;
`endif
    end
  end

  assign req_ready_o  = ready_q;
  assign beat_valid_o = valid_q;
  assign beat_adr_o   = adr_q;
  assign beat_sel_o   = sel_q;
  assign beat_ofs_o   = ofs_q;
  assign beat_we_o    = we_q;
  assign beat_first_o = first_q;
  assign beat_last_o  = last_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_any1_sel_seq.sv
// Bench for any1_sel_seq (DBW=128, ABW=32): byte-walk reference model plus
// hand-computed literal checks; follows ANY1_SEL_SPLIT_EN like the design.
module tb_any1_sel_seq;

  localparam int DBW = 128;
  localparam int ABW = 32;
`ifdef ANY1_SEL_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, req_valid, req_we, beat_ready;
  logic [31:0] req_adr;
  logic [2:0]  req_size;
  logic        req_ready_o, beat_valid_o, beat_we_o, beat_first_o, beat_last_o, err_o;
  logic [31:0] beat_adr_o;
  logic [15:0] beat_sel_o;
  logic [3:0]  beat_ofs_o;

  always #5 clk = ~clk;

  any1_sel_seq #(.DBW(DBW), .ABW(ABW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_adr_i    (req_adr),
    .req_size_i   (req_size),
    .req_we_i     (req_we),
    .beat_valid_o (beat_valid_o),
    .beat_ready_i (beat_ready),
    .beat_adr_o   (beat_adr_o),
    .beat_sel_o   (beat_sel_o),
    .beat_ofs_o   (beat_ofs_o),
    .beat_we_o    (beat_we_o),
    .beat_first_o (beat_first_o),
    .beat_last_o  (beat_last_o),
    .err_o        (err_o)
  );

  typedef struct {
    logic [31:0] adr;
    logic [15:0] sel;
    logic [3:0]  ofs;
    logic        we;
    logic        first;
    logic        last;
  } beat_t;

  beat_t m_q[$];
  logic  m_ready = 1'b1;
  logic  m_err   = 1'b0;
  bit    chk_en  = 1'b0;
  int    n_chk   = 0;
  int    n_err   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Walk each accessed byte; bytes landing in the next bus word form beat 1.
  function automatic void model_req(input logic [31:0] adr, input logic [2:0] size,
                                    input logic we, output logic e);
    logic [31:0] base, a;
    logic [15:0] s0, s1;
    int          nbytes, off;
    e = 1'b0;
    if (size > 3'd4) begin
      e = 1'b1;
      return;
    end
    nbytes = 1 << size;
    base   = adr & ~32'hF;
    off    = int'(adr[3:0]);
    s0     = '0;
    s1     = '0;
    for (int b = 0; b < nbytes; b++) begin
      a = adr + 32'(b);
      if ((a & ~32'hF) == base) s0[a[3:0]] = 1'b1;
      else                      s1[a[3:0]] = 1'b1;
    end
    if (s1 != 16'h0 && !SPLIT) begin
      e = 1'b1;
      return;
    end
    m_q.push_back('{base, s0, 4'(off), we, 1'b1, (s1 == 16'h0)});
    if (s1 != 16'h0) m_q.push_back('{base + 32'd16, s1, 4'(16 - off), we, 1'b0, 1'b1});
  endfunction

  always @(posedge clk) begin : model
    logic e;
    e = 1'b0;
    if (rst) begin
      m_q.delete();
      m_err   <= 1'b0;
      m_ready <= 1'b1;
    end else begin
      if (m_q.size() != 0 && beat_ready) void'(m_q.pop_front());
      if (m_ready && req_valid) model_req(req_adr, req_size, req_we, e);
      m_err   <= e;
      m_ready <= (m_q.size() == 0);
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      chk("ready", 32'(req_ready_o), 32'(m_ready));
      chk("err",   32'(err_o),       32'(m_err));
      chk("valid", 32'(beat_valid_o), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("adr",   beat_adr_o,          m_q[0].adr);
        chk("sel",   32'(beat_sel_o),     32'(m_q[0].sel));
        chk("ofs",   32'(beat_ofs_o),     32'(m_q[0].ofs));
        chk("we",    32'(beat_we_o),      32'(m_q[0].we));
        chk("first", 32'(beat_first_o),   32'(m_q[0].first));
        chk("last",  32'(beat_last_o),    32'(m_q[0].last));
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [2:0] s, input logic w);
    req_adr   = a;
    req_size  = s;
    req_we    = w;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!m_ready && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (k >= 30) begin
      n_chk++;
      n_err++;
      $display("FAIL idle_timeout at %0t: got busy expected idle", $time);
    end
  endtask

  logic [31:0] va [10] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_000F, 32'h0000_0007,
                           32'h0000_000E, 32'hABCD_0008, 32'h0000_0000, 32'h0000_0003,
                           32'h0000_0010, 32'h0000_0009};
  logic [2:0]  vs [10] = '{3'd4, 3'd4, 3'd1, 3'd0, 3'd2, 3'd3, 3'd6, 3'd7, 3'd1, 3'd3};

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got no finish expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_adr = '0; req_size = '0; req_we = 1'b0;
    beat_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_valid", 32'(beat_valid_o), 32'd0);
    chk("rst_sel",   32'(beat_sel_o), 32'd0);
    chk("rst_adr",   beat_adr_o, 32'd0);
    chk("rst_ofs",   32'(beat_ofs_o), 32'd0);
    chk("rst_flags", 32'({beat_we_o, beat_first_o, beat_last_o, err_o}), 32'd0);
    rst = 1'b0;

    // single aligned-within-word beat
    send(32'h1004, 3'd2, 1'b1);
    chk("c1_adr", beat_adr_o, 32'h1000);
    chk("c1_sel", 32'(beat_sel_o), 32'h00F0);
    chk("c1_ofs", 32'(beat_ofs_o), 32'd4);
    chk("c1_fl",  32'({beat_valid_o, beat_first_o, beat_last_o, beat_we_o}), 32'hF);
    wait_idle();

    // word-crossing access
    send(32'h100C, 3'd3, 1'b0);
`ifdef ANY1_SEL_SPLIT_EN
    chk("c2_b0_adr", beat_adr_o, 32'h1000);
    chk("c2_b0_sel", 32'(beat_sel_o), 32'hF000);
    chk("c2_b0_ofs", 32'(beat_ofs_o), 32'd12);
    chk("c2_b0_fl",  32'({beat_first_o, beat_last_o}), 32'h2);
    @(negedge clk);
    chk("c2_b1_adr", beat_adr_o, 32'h1010);
    chk("c2_b1_sel", 32'(beat_sel_o), 32'h000F);
    chk("c2_b1_ofs", 32'(beat_ofs_o), 32'd4);
    chk("c2_b1_fl",  32'({beat_first_o, beat_last_o}), 32'h1);
`else
    chk("c2_err",   32'(err_o), 32'd1);
    chk("c2_valid", 32'(beat_valid_o), 32'd0);
`endif
    wait_idle();

    // stalled first beat
    beat_ready = 1'b0;
    send(32'h100C, 3'd3, 1'b0);
`ifdef ANY1_SEL_SPLIT_EN
    for (int i = 0; i < 4; i++) begin
      chk("c3_hold_sel",   32'(beat_sel_o), 32'hF000);
      chk("c3_hold_adr",   beat_adr_o, 32'h1000);
      chk("c3_hold_ready", 32'(req_ready_o), 32'd0);
      if (i < 3) @(negedge clk);
    end
    beat_ready = 1'b1;
    @(negedge clk);
    chk("c3_b1_sel",   32'(beat_sel_o), 32'h000F);
    chk("c3_b1_ready", 32'(req_ready_o), 32'd0);
`else
    chk("c3_err", 32'(err_o), 32'd1);
    beat_ready = 1'b1;
`endif
    wait_idle();

    // illegal size
    send(32'h1234, 3'd5, 1'b0);
    chk("c4_err",   32'(err_o), 32'd1);
    chk("c4_valid", 32'(beat_valid_o), 32'd0);
    @(negedge clk);
    chk("c4_err_clr", 32'(err_o), 32'd0);
    chk("c4_ready",   32'(req_ready_o), 32'd1);
    wait_idle();

    // address wrap at top of space
    send(32'hFFFF_FFFC, 3'd3, 1'b1);
`ifdef ANY1_SEL_SPLIT_EN
    chk("c5_b0_adr", beat_adr_o, 32'hFFFF_FFF0);
    chk("c5_b0_sel", 32'(beat_sel_o), 32'hF000);
    @(negedge clk);
    chk("c5_b1_adr", beat_adr_o, 32'h0000_0000);
    chk("c5_b1_sel", 32'(beat_sel_o), 32'h000F);
    chk("c5_b1_ofs", 32'(beat_ofs_o), 32'd4);
`else
    chk("c5_err", 32'(err_o), 32'd1);
`endif
    wait_idle();

    // reset with a pending beat
`ifdef ANY1_SEL_SPLIT_EN
    beat_ready = 1'b0;
    send(32'h100C, 3'd3, 1'b0);
    beat_ready = 1'b1;
    @(negedge clk);
    beat_ready = 1'b0;
    chk("c6_in_b1", 32'({beat_valid_o, beat_first_o, beat_last_o}), 32'h5);
`endif
    rst = 1'b1;
    @(negedge clk);
    chk("c6_valid", 32'(beat_valid_o), 32'd0);
    chk("c6_ready", 32'(req_ready_o), 32'd1);
    rst = 1'b0;
    beat_ready = 1'b1;
    send(32'h0000_0002, 3'd0, 1'b0);
    chk("c6_sel", 32'(beat_sel_o), 32'h0004);
    chk("c6_ofs", 32'(beat_ofs_o), 32'd2);
    wait_idle();

    // directed vectors checked against the model
    for (int i = 0; i < 10; i++) begin
      wait_idle();
      send(va[i], vs[i], 1'(i));
    end
    wait_idle();

    // request held valid: aligned requests accepted every other cycle
    req_adr = 32'h40; req_size = 3'd2; req_we = 1'b1; req_valid = 1'b1;
    repeat (6) @(negedge clk);
    req_valid = 1'b0;
    wait_idle();

    // held request with a toggling beat_ready
    req_adr = 32'h8E; req_size = 3'd2; req_we = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      beat_ready = ~beat_ready;
    end
    req_valid = 1'b0;
    beat_ready = 1'b1;
    wait_idle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
